// File: rtl/vga_desenho_embarcacao.sv
// rtl/vga_desenho_embarcacao.sv - frame-synchronous ship-cell overlay on a 15x15 VGA grid (optional grid lines: VGA_DESENHO_GRADE_EN)
module vga_desenho_embarcacao #(
    parameter int         GRID_X0   = 80,
    parameter int         GRID_Y0   = 0,
    parameter logic [7:0] COR_NAVIO = 8'hE0,
    parameter logic [7:0] COR_AGUA  = 8'h03
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [63:0] posicoesEmbarcacao,
    input  logic        frame_start,
    input  logic        video_on,
    input  logic [9:0]  pixel_x,
    input  logic [9:0]  pixel_y,
    output logic [7:0]  rgb,
    output logic [2:0]  celulas_validas,
    output logic        atualizado
);

    localparam logic [10:0] X_LO = 11'(GRID_X0);
    localparam logic [10:0] X_HI = 11'(GRID_X0 + 480);
    localparam logic [10:0] Y_LO = 11'(GRID_Y0);
    localparam logic [10:0] Y_HI = 11'(GRID_Y0 + 480);
    localparam logic [9:0]  X_LO10 = 10'(GRID_X0);
    localparam logic [9:0]  Y_LO10 = 10'(GRID_Y0);

    // Only bits [42:3] carry cell data; the rest is deliberately dropped.
    logic [39:0] snap;
    logic        unused_bits;
    assign unused_bits = ^{posicoesEmbarcacao[63:43], posicoesEmbarcacao[2:0]};

    logic [39:0] novo;
    logic [2:0]  contagem;
    assign novo = posicoesEmbarcacao[42:3];

    always_comb begin
        contagem = '0;
        for (int k = 0; k < 5; k++) begin
            if (novo[8*k +: 4] != 4'd0 && novo[8*k+4 +: 4] != 4'd0)
                contagem = contagem + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            snap            <= '0;
            celulas_validas <= '0;
            atualizado      <= 1'b0;
        end else begin
            atualizado <= 1'b0;
            if (frame_start) begin
                snap            <= novo;
                celulas_validas <= contagem;
                atualizado      <= (novo != snap);
            end
        end
    end

    // Stage 1: grid membership and cell coordinates (1-based).
    logic       s1_in, s1_vo;
    logic [3:0] s1_col, s1_row;
    logic       in_grid_w;
    assign in_grid_w = ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI) &&
                       ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);

`ifdef VGA_DESENHO_GRADE_EN
    logic [4:0] s1_ox, s1_oy;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_in  <= 1'b0;
            s1_vo  <= 1'b0;
            s1_col <= '0;
            s1_row <= '0;
`ifdef VGA_DESENHO_GRADE_EN
            s1_ox  <= '0;
            s1_oy  <= '0;
`endif
        end else begin
            s1_in  <= in_grid_w;
            s1_vo  <= video_on;
            s1_col <= 4'((pixel_x - X_LO10) >> 5) + 4'd1;
            s1_row <= 4'((pixel_y - Y_LO10) >> 5) + 4'd1;
`ifdef VGA_DESENHO_GRADE_EN
            s1_ox  <= pixel_x[4:0] - X_LO10[4:0];
            s1_oy  <= pixel_y[4:0] - Y_LO10[4:0];
`endif
        end
    end

    // Stage 2: match against every valid snapshot cell (duplicates simply OR).
    logic acerto;
    always_comb begin
        acerto = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (snap[8*k +: 4] != 4'd0 && snap[8*k+4 +: 4] != 4'd0 &&
                snap[8*k +: 4] == s1_col && snap[8*k+4 +: 4] == s1_row)
                acerto = 1'b1;
        end
        acerto = acerto & s1_in;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rgb <= 8'h00;
        end else if (!s1_vo) begin
            rgb <= 8'h00;
        end else if (acerto) begin
            rgb <= COR_NAVIO;
        end else if (s1_in) begin
`ifdef VGA_DESENHO_GRADE_EN
            rgb <= (s1_ox == 5'd0 || s1_oy == 5'd0) ? 8'hFF : COR_AGUA;
`else
            rgb <= COR_AGUA;
`endif
        end else begin
            rgb <= 8'h00;
        end
    end

endmodule

// File: tb/tb_vga_desenho_embarcacao.sv
// tb/tb_vga_desenho_embarcacao.sv - directed self-checking bench for vga_desenho_embarcacao
module tb_vga_desenho_embarcacao;

    logic        clk = 1'b0;
    logic        reset;
    logic [63:0] posicoesEmbarcacao;
    logic        frame_start;
    logic        video_on;
    logic [9:0]  pixel_x, pixel_y;
    logic [7:0]  rgb;
    logic [2:0]  celulas_validas;
    logic        atualizado;

    int checks = 0;
    int failures = 0;

`ifdef VGA_DESENHO_GRADE_EN
    localparam logic [7:0] LINHA = 8'hFF;
`else
    localparam logic [7:0] LINHA = 8'h03;
`endif

    vga_desenho_embarcacao dut (
        .clk(clk), .reset(reset), .posicoesEmbarcacao(posicoesEmbarcacao),
        .frame_start(frame_start), .video_on(video_on),
        .pixel_x(pixel_x), .pixel_y(pixel_y),
        .rgb(rgb), .celulas_validas(celulas_validas), .atualizado(atualizado)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] cel(input int x, input int y, input int k);
        logic [63:0] v;
        v = 64'((y << 4) | x);
        return v << (8 * k + 3);
    endfunction

    task automatic pix(input string tag, input int x, input int y, input logic vo,
                       input logic [7:0] exp);
        pixel_x  = 10'(x);
        pixel_y  = 10'(y);
        video_on = vo;
        step();
        step();
        chk(tag, rgb, exp);
    endtask

    logic [63:0] v5;

    initial begin
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            posicoesEmbarcacao = {$urandom, $urandom};
            frame_start = 1'($urandom);
            video_on    = 1'b1;
            pixel_x     = 10'd85;
            pixel_y     = 10'd5;
            step();
            chk("rst_rgb", rgb, 8'h00);
            chk("rst_cv", {5'd0, celulas_validas}, 8'd0);
            chk("rst_at", {7'd0, atualizado}, 8'd0);
        end

        // first capture coinciding with the (80,0) pixel
        reset = 1'b1;
        posicoesEmbarcacao = 64'h88;
        frame_start = 1'b1;
        pixel_x = 10'd80; pixel_y = 10'd0; video_on = 1'b1;
        step();
        chk("cap_at", {7'd0, atualizado}, 8'd1);
        chk("cap_cv", {5'd0, celulas_validas}, 8'd1);
        frame_start = 1'b0;
        step();
        chk("cap_rgb", rgb, 8'hE0);
        chk("cap_at_once", {7'd0, atualizado}, 8'd0);

        pix("cell21_line", 112, 0, 1'b1, LINHA);
        pix("left_of_grid", 79, 0, 1'b1, 8'h00);
        pix("video_off", 80, 0, 1'b0, 8'h00);
        pix("ship_inner", 111, 31, 1'b1, 8'hE0);
        pix("right_of_grid", 560, 0, 1'b1, 8'h00);
        pix("below_grid", 100, 480, 1'b1, 8'h00);
        pix("water_inner", 550, 470, 1'b1, 8'h03);

        // mid-frame vector change stays invisible
        posicoesEmbarcacao = cel(15, 15, 0);
        pix("midframe_old", 530, 450, 1'b1, 8'h03);
        pix("midframe_keep", 85, 5, 1'b1, 8'hE0);
        frame_start = 1'b1;
        pixel_x = 10'd530; pixel_y = 10'd450;
        step();
        frame_start = 1'b0;
        chk("f2_at", {7'd0, atualizado}, 8'd1);
        chk("f2_cv", {5'd0, celulas_validas}, 8'd1);
        step();
        chk("f2_rgb", rgb, 8'hE0);
        pix("f2_old_gone", 85, 5, 1'b1, 8'h03);

        // unchanged capture, ignored bits toggled
        posicoesEmbarcacao = cel(15, 15, 0) | 64'hFFFF_F800_0000_0007;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("same_no_at", {7'd0, atualizado}, 8'd0);

        // five valid cells, two identical
        v5 = cel(1, 1, 0) | cel(1, 1, 1) | cel(2, 3, 2) | cel(15, 1, 3) | cel(5, 5, 4);
        posicoesEmbarcacao = v5;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("five_cv", {5'd0, celulas_validas}, 8'd5);
        chk("five_at", {7'd0, atualizado}, 8'd1);
        pix("five_c2", 117, 69, 1'b1, 8'hE0);
        pix("five_c3", 559, 31, 1'b1, 8'hE0);
        pix("five_c4", 239, 159, 1'b1, 8'hE0);

        // one cell with Y=0 is invalid
        posicoesEmbarcacao = cel(1, 1, 0) | cel(3, 0, 1);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("inval_cv", {5'd0, celulas_validas}, 8'd1);
        posicoesEmbarcacao = v5;
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;

        // reset during a ship stream
        pixel_x = 10'd117; pixel_y = 10'd69; video_on = 1'b1;
        step();
        step();
        chk("pre_rst_rgb", rgb, 8'hE0);
        reset = 1'b0;
        step();
        chk("midrst_rgb", rgb, 8'h00);
        chk("midrst_cv", {5'd0, celulas_validas}, 8'd0);
        reset = 1'b1;
        step();
        chk("postrst_at", {7'd0, atualizado}, 8'd0);
        step();
        chk("postrst_hidden", rgb, 8'h03);
        frame_start = 1'b1;
        step();
        frame_start = 1'b0;
        chk("postrst_at2", {7'd0, atualizado}, 8'd1);
        step();
        chk("postrst_ship", rgb, 8'hE0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
